// File: rtl/id_ex_hazard_reg.sv
// id_ex_hazard_reg: ID/EX pipeline register with load-use hazard detection.
// Captures the decoded instruction from ID each cycle. When that instruction
// reads a register that the load now in EX has not yet produced, it inserts
// one bubble and freezes PC and IF/ID. It flushes ID on a taken branch.
// Priority per cycle: hold > branch_taken > load-use > normal.
// Optional build macro: HAZARD_STATS_EN adds saturating stall, flush and hold
// event counters.
module id_ex_hazard_reg #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              hold,
    input  logic              branch_taken,
    input  logic [REG_W-1:0]  ID_Rn,
    input  logic [REG_W-1:0]  ID_Rm,
    input  logic [REG_W-1:0]  ID_Rd,
    input  logic              ID_uses_Rn,
    input  logic              ID_uses_Rm,
    input  logic              ID_regWrite,
    input  logic              ID_memRead,
    input  logic              ID_memWrite,
    input  logic              ID_memToReg,
    input  logic              ID_ALUsrc,
    input  logic [2:0]        ID_ALUop,
    input  logic [DATA_W-1:0] ID_RnData,
    input  logic [DATA_W-1:0] ID_RmData,
    input  logic [DATA_W-1:0] ID_imm,
    output logic [REG_W-1:0]  ID_EX_Rn,
    output logic [REG_W-1:0]  ID_EX_Rm,
    output logic [REG_W-1:0]  ID_EX_Rd,
    output logic              ID_EX_regWrite,
    output logic              ID_EX_memRead,
    output logic              ID_EX_memWrite,
    output logic              ID_EX_memToReg,
    output logic              ID_EX_ALUsrc,
    output logic [2:0]        ID_EX_ALUop,
    output logic [DATA_W-1:0] ID_EX_RnData,
    output logic [DATA_W-1:0] ID_EX_RmData,
    output logic [DATA_W-1:0] ID_EX_imm,
    output logic              PC_write,
    output logic              IF_ID_write,
    output logic              stall
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_count,
    output logic [31:0]       flush_count,
    output logic [31:0]       hold_count
`endif
);

    // Register 31 is XZR: a bubble uses it so the forwarding unit never matches.
    localparam logic [REG_W-1:0] XZR = '1;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [REG_W-1:0]  r_rn, r_rm, r_rd;
    logic              r_reg_write, r_mem_read, r_mem_write, r_mem_to_reg, r_alu_src;
    logic [2:0]        r_alu_op;
    logic [DATA_W-1:0] r_rn_data, r_rm_data, r_imm;

    logic [REG_W-1:0]  w_rn_next, w_rm_next, w_rd_next;
    logic              w_reg_write_next, w_mem_read_next, w_mem_write_next;
    logic              w_mem_to_reg_next, w_alu_src_next;
    logic [2:0]        w_alu_op_next;
    logic [DATA_W-1:0] w_rn_data_next, w_rm_data_next, w_imm_next;

    logic w_lu_hz;
    logic w_do_flush;
    logic w_do_stall;
    logic w_bubble;

    // Load in EX whose destination is read by the instruction in ID.
    assign w_lu_hz = r_mem_read && (r_rd != XZR) &&
                     ((ID_uses_Rn && (ID_Rn == r_rd)) ||
                      (ID_uses_Rm && (ID_Rm == r_rd)));

    assign w_do_flush = !hold && branch_taken;
    assign w_do_stall = !hold && !branch_taken && w_lu_hz;
    assign w_bubble   = w_do_flush || w_do_stall;

    // Next-state, enables and next ID/EX contents, ordered by priority.
    always_comb begin
        w_state_next      = r_state;
        PC_write          = 1'b1;
        IF_ID_write       = 1'b1;
        stall             = 1'b0;
        w_rn_next         = ID_Rn;
        w_rm_next         = ID_Rm;
        w_rd_next         = ID_Rd;
        w_reg_write_next  = ID_regWrite;
        w_mem_read_next   = ID_memRead;
        w_mem_write_next  = ID_memWrite;
        w_mem_to_reg_next = ID_memToReg;
        w_alu_src_next    = ID_ALUsrc;
        w_alu_op_next     = ID_ALUop;
        w_rn_data_next    = ID_RnData;
        w_rm_data_next    = ID_RmData;
        w_imm_next        = ID_imm;
        if (hold) begin
            PC_write          = 1'b0;
            IF_ID_write       = 1'b0;
            w_rn_next         = r_rn;
            w_rm_next         = r_rm;
            w_rd_next         = r_rd;
            w_reg_write_next  = r_reg_write;
            w_mem_read_next   = r_mem_read;
            w_mem_write_next  = r_mem_write;
            w_mem_to_reg_next = r_mem_to_reg;
            w_alu_src_next    = r_alu_src;
            w_alu_op_next     = r_alu_op;
            w_rn_data_next    = r_rn_data;
            w_rm_data_next    = r_rm_data;
            w_imm_next        = r_imm;
        end else begin
            if (w_bubble) begin
                w_rn_next         = XZR;
                w_rm_next         = XZR;
                w_rd_next         = XZR;
                w_reg_write_next  = 1'b0;
                w_mem_read_next   = 1'b0;
                w_mem_write_next  = 1'b0;
                w_mem_to_reg_next = 1'b0;
                w_alu_src_next    = 1'b0;
                w_alu_op_next     = 3'd0;
                w_rn_data_next    = '0;
                w_rm_data_next    = '0;
                w_imm_next        = '0;
            end
            if (w_do_stall) begin
                PC_write     = 1'b0;
                IF_ID_write  = 1'b0;
                stall        = 1'b1;
                w_state_next = BUBBLE;
            end else begin
                w_state_next = RUN;
            end
        end
    end

    // State and ID/EX register update; reset parks register numbers on XZR.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= RUN;
            r_rn         <= XZR;
            r_rm         <= XZR;
            r_rd         <= XZR;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_src    <= 1'b0;
            r_alu_op     <= 3'd0;
            r_rn_data    <= '0;
            r_rm_data    <= '0;
            r_imm        <= '0;
        end else begin
            r_state      <= w_state_next;
            r_rn         <= w_rn_next;
            r_rm         <= w_rm_next;
            r_rd         <= w_rd_next;
            r_reg_write  <= w_reg_write_next;
            r_mem_read   <= w_mem_read_next;
            r_mem_write  <= w_mem_write_next;
            r_mem_to_reg <= w_mem_to_reg_next;
            r_alu_src    <= w_alu_src_next;
            r_alu_op     <= w_alu_op_next;
            r_rn_data    <= w_rn_data_next;
            r_rm_data    <= w_rm_data_next;
            r_imm        <= w_imm_next;
        end
    end

    // A bubble holds memRead low, so a hazard while in BUBBLE means broken logic.
    a_no_hazard_in_bubble: assert property (@(posedge clk) disable iff (!reset_n)
        (r_state == BUBBLE && !hold) |-> !w_lu_hz);

    assign ID_EX_Rn       = r_rn;
    assign ID_EX_Rm       = r_rm;
    assign ID_EX_Rd       = r_rd;
    assign ID_EX_regWrite = r_reg_write;
    assign ID_EX_memRead  = r_mem_read;
    assign ID_EX_memWrite = r_mem_write;
    assign ID_EX_memToReg = r_mem_to_reg;
    assign ID_EX_ALUsrc   = r_alu_src;
    assign ID_EX_ALUop    = r_alu_op;
    assign ID_EX_RnData   = r_rn_data;
    assign ID_EX_RmData   = r_rm_data;
    assign ID_EX_imm      = r_imm;

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_count, r_flush_count, r_hold_count;

    // Count the winning condition of each cycle, saturating at all ones.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
            r_hold_count  <= '0;
        end else begin
            if (w_do_stall && (r_stall_count != 32'hFFFF_FFFF))
                r_stall_count <= r_stall_count + 32'd1;
            if (w_do_flush && (r_flush_count != 32'hFFFF_FFFF))
                r_flush_count <= r_flush_count + 32'd1;
            if (hold && (r_hold_count != 32'hFFFF_FFFF))
                r_hold_count <= r_hold_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;
    assign hold_count  = r_hold_count;
`endif

endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
- ID/EX pipeline register combined with load-use hazard detection, for the 5-stage pipelined ARM CPU.
- Captures decoded operands, register numbers and control from the ID stage each cycle. Drives the ID_EX_* fields consumed by the EX stage and the forwarding unit.
- Inserts one bubble and freezes PC and IF/ID when an instruction in ID needs a value that a load in EX has not yet produced. Flushes on a taken branch.

Parameters:
- DATA_W, 64, width of the register-file operands and the immediate.
- REG_W, 5, width of a register number; register 31 (all ones) is XZR and is never a hazard source.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- hold  in  1  global freeze, e.g. memory busy.
- branch_taken  in  1  flush the wrong-path instruction currently in ID.
- ID_Rn, ID_Rm, ID_Rd  in  REG_W  register numbers of the instruction in ID.
- ID_uses_Rn, ID_uses_Rm  in  1  marks the instruction in ID as actually reading that operand.
- ID_regWrite, ID_memRead, ID_memWrite, ID_memToReg, ID_ALUsrc  in  1  decoded control bits.
- ID_ALUop  in  3  ALU operation.
- ID_RnData, ID_RmData, ID_imm  in  DATA_W  operand values and sign-extended immediate.
- ID_EX_Rn, ID_EX_Rm, ID_EX_Rd  out  REG_W  registered register numbers.
- ID_EX_regWrite, ID_EX_memRead, ID_EX_memWrite, ID_EX_memToReg, ID_EX_ALUsrc  out  1  registered control bits.
- ID_EX_ALUop  out  3  registered ALU operation.
- ID_EX_RnData, ID_EX_RmData, ID_EX_imm  out  DATA_W  registered operand data.
- PC_write  out  1  PC update enable (combinational).
- IF_ID_write  out  1  IF/ID register update enable (combinational).
- stall  out  1  a load-use bubble is being inserted this cycle (combinational).

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - All ID_EX_* outputs go to 0, except ID_EX_Rn, ID_EX_Rm and ID_EX_Rd, which go to 31 so the forwarding unit never matches.
  - FSM goes to RUN.
  - Reset overrides every other input, including mid-stall.
- Hazard term (combinational, from registered state):
  - lu_hz = ID_EX_memRead & (ID_EX_Rd != 31) & ((ID_uses_Rn & ID_Rn == ID_EX_Rd) | (ID_uses_Rm & ID_Rm == ID_EX_Rd)).
- Priority per cycle: hold > branch_taken > lu_hz > normal.
- hold=1:
  - The ID/EX register keeps its value.
  - PC_write=0, IF_ID_write=0, stall=0.
  - FSM does not change.
- branch_taken=1 (hold=0):
  - ID/EX loads a bubble: all control bits 0, register numbers 31, data don't-care (loaded as 0).
  - PC_write=1, IF_ID_write=1, stall=0. lu_hz is ignored because ID holds a wrong-path instruction.
  - FSM goes to RUN.
- lu_hz=1 (hold=0, branch_taken=0):
  - ID/EX loads a bubble.
  - PC_write=0, IF_ID_write=0, stall=1.
  - FSM goes RUN -> BUBBLE.
- Normal:
  - ID/EX loads all ID_* inputs.
  - PC_write=1, IF_ID_write=1, stall=0.
  - FSM goes to RUN.
- FSM states:
  - RUN: no bubble was inserted last cycle.
  - BUBBLE: a load-use bubble sits in ID/EX.
  - In BUBBLE, ID_EX_memRead=0, so lu_hz is 0 by construction and the stalled instruction advances on the next cycle.
  - BUBBLE -> RUN on any non-hold cycle. lu_hz asserting while in BUBBLE is a design error; the block flags it as an assertion.
- Stall length: exactly one bubble per load-use dependency. Total latency ID -> ID_EX_* is one cycle when no hazard, two cycles when stalled.
- Rd of 31 (XZR) loads never stall. Instructions with ID_uses_Rn/ID_uses_Rm = 0 never stall on that operand.
- Simultaneous branch_taken and lu_hz: flush wins and no stall is asserted.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, add these outputs:
  - stall_count  out  32
  - flush_count  out  32
  - hold_count  out  32
- Each counter increments by 1 on every clock edge where its condition was the winning priority. Counters saturate at 0xFFFFFFFF and clear on reset.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset: assert reset_n=0 with random ID inputs for 2 cycles -> all ID_EX control=0, ID_EX_Rn/Rm/Rd=31, PC_write=1, stall=0 after release.
- Load-use on Rn:
  - Cycle 1: LDUR X5 in ID (memRead=1, Rd=5). Cycle 2: ADD in ID with Rn=5, uses_Rn=1.
  - Cycle 2 -> stall=1, PC_write=0, IF_ID_write=0; next ID_EX_regWrite=0, ID_EX_Rd=31.
  - Cycle 3: stall=0 and ID_EX_Rn=5 loads.
- No false stall:
  - Load to X31 followed by a reader of X31 -> stall=0.
  - Load to X5 followed by ADDI with Rm=5 but uses_Rm=0 -> stall=0.
- Flush beats stall: load-use condition present and branch_taken=1 in the same cycle -> stall=0, PC_write=1, bubble loaded into ID/EX, FSM=RUN.
- Hold:
  - ID_EX holding Rd=7, regWrite=1; assert hold for 3 cycles with changing ID inputs -> ID_EX_Rd stays 7, PC_write=0.
  - With HAZARD_STATS_EN, hold_count=3.
- Reset mid-stall: assert reset_n=0 in the cycle that stall=1 -> next cycle FSM=RUN, ID_EX_memRead=0; with HAZARD_STATS_EN, stall_count=0.
